// File: rtl/bus_xbar_rr.sv
// Round-robin NUM_M x NUM_S bus crossbar that moves one transfer at a time through IDLE -> BUSY -> RESP.
// An unmapped address, or a slave that never acks, completes the transfer with an error response.
module bus_xbar_rr #(
   parameter int NUM_M   = 2,
   parameter int NUM_S   = 4,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int SEL_W   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_M-1:0]    m_req_i,
   input  logic [NUM_M-1:0]    m_we_i,
   input  logic [NUM_M*AW-1:0] m_addr_i,
   input  logic [NUM_M*DW-1:0] m_wdata_i,
   output logic [NUM_M*DW-1:0] m_rdata_o,
   output logic [NUM_M-1:0]    m_ack_o,
   output logic [NUM_M-1:0]    m_err_o,
   output logic [NUM_S-1:0]    s_req_o,
   output logic                s_we_o,
   output logic [AW-1:0]       s_addr_o,
   output logic [DW-1:0]       s_wdata_o,
   input  logic [NUM_S*DW-1:0] s_rdata_i,
   input  logic [NUM_S-1:0]    s_ack_i,
   output logic [NUM_M-1:0]    grant_o,
   output logic                hold_flag_o
);

   localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t            state_q, state_d;
   logic [NUM_M-1:0]  grant_q, grant_d;
   logic [MW-1:0]     ptr_q, ptr_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic              we_q, we_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [15:0]       cnt_q, cnt_d;

   logic              any_req;
   logic [MW-1:0]     win;
   logic [AW-1:0]     win_addr;
   logic              win_we;
   logic [DW-1:0]     win_wdata;
   logic              sel_ack;
   logic [DW-1:0]     sel_rdata;

   // Rotating priority: the search starts at the master after the last winner.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      any_req   = 1'b0;
      win       = '0;
      win_addr  = '0;
      win_we    = 1'b0;
      win_wdata = '0;
      for (int i = 1; i <= NUM_M; i++) begin
         for (int m = 0; m < NUM_M; m++) begin
            if (!any_req && m == (int'(ptr_q) + i) % NUM_M && m_req_i[m]) begin
               any_req = 1'b1;
               win     = MW'(m);
            end
         end
      end
      for (int m = 0; m < NUM_M; m++) begin
         if (win == MW'(m)) begin
            win_addr  = m_addr_i[m*AW +: AW];
            win_we    = m_we_i[m];
            win_wdata = m_wdata_i[m*DW +: DW];
         end
      end
   end

   // Only the addressed slave's ack and read data are looked at.
   always_comb begin
      sel_ack   = 1'b0;
      sel_rdata = '0;
      for (int s = 0; s < NUM_S; s++) begin
         if (sel_q == SEL_W'(s)) begin
            sel_ack   = s_ack_i[s];
            sel_rdata = s_rdata_i[s*DW +: DW];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               for (int m = 0; m < NUM_M; m++) grant_d[m] = (win == MW'(m));
               ptr_d   = win;
               addr_d  = win_addr;
               we_d    = win_we;
               wdata_d = win_wdata;
               sel_d   = win_addr[AW-1 -: SEL_W];
               cnt_d   = '0;
               rdata_d = '0;
               err_d   = 1'b0;
               if (int'(win_addr[AW-1 -: SEL_W]) < NUM_S) begin
                  state_d = BUSY;
               end else begin
                  state_d = RESP;
                  err_d   = 1'b1;
               end
            end
         end
         BUSY: begin
            if (sel_ack) begin
               rdata_d = we_q ? '0 : sel_rdata;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == 16'(TIMEOUT - 1)) begin
               // This is the TIMEOUT-th BUSY cycle without an ack.
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RESP: begin
            grant_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= MW'(NUM_M - 1);
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         sel_q   <= '0;
         cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

   // Slave request and master response decode straight from the state register, so reset drops them at once.
   always_comb begin
      s_req_o   = '0;
      m_ack_o   = '0;
      m_err_o   = '0;
      m_rdata_o = '0;
      for (int s = 0; s < NUM_S; s++) begin
         if (state_q == BUSY && sel_q == SEL_W'(s)) s_req_o[s] = 1'b1;
      end
      for (int m = 0; m < NUM_M; m++) begin
         if (state_q == RESP && grant_q[m]) begin
            m_ack_o[m]             = 1'b1;
            m_err_o[m]             = err_q;
            m_rdata_o[m*DW +: DW]  = rdata_q;
         end
      end
   end

   assign grant_o     = grant_q;
   assign s_addr_o    = addr_q;
   assign s_we_o      = we_q;
   assign s_wdata_o   = wdata_q;
   assign hold_flag_o = |(m_req_i & ~m_ack_o);

endmodule

// File: tb/tb_bus_xbar_rr.sv
// Directed bench for bus_xbar_rr: read, wait-state write, unmapped, timeout, async reset, round-robin.
module tb_bus_xbar_rr;

   localparam int NUM_M = 2;
   localparam int NUM_S = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;

   logic                clk = 1'b0;
   logic                rst;
   logic [NUM_M-1:0]    m_req;
   logic [NUM_M-1:0]    m_we;
   logic [NUM_M*AW-1:0] m_addr;
   logic [NUM_M*DW-1:0] m_wdata;
   logic [NUM_M*DW-1:0] m_rdata_o;
   logic [NUM_M-1:0]    m_ack_o;
   logic [NUM_M-1:0]    m_err_o;
   logic [NUM_S-1:0]    s_req_o;
   logic                s_we_o;
   logic [AW-1:0]       s_addr_o;
   logic [DW-1:0]       s_wdata_o;
   logic [NUM_S*DW-1:0] s_rdata;
   logic [NUM_S-1:0]    s_ack;
   logic [NUM_S-1:0]    auto_ack;
   logic [NUM_S-1:0]    man_ack;
   logic [NUM_M-1:0]    grant_o;
   logic                hold_flag_o;

   int n_tests = 0;
   int n_fail  = 0;

   // Zero-wait slaves answer in the same cycle they are selected; others are acked by hand.
   assign s_ack = (s_req_o & auto_ack) | man_ack;

   always #5 clk = ~clk;

   bus_xbar_rr #(
      .NUM_M(NUM_M), .NUM_S(NUM_S), .AW(AW), .DW(DW), .SEL_W(4), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst),
      .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
      .m_rdata_o(m_rdata_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
      .s_rdata_i(s_rdata), .s_ack_i(s_ack),
      .grant_o(grant_o), .hold_flag_o(hold_flag_o)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   logic [1:0] rr_grant [12] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                                 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
   logic [1:0] rr_ack   [12] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00,
                                 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};

   initial begin
      rst = 1'b0; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
      s_rdata = '0; auto_ack = '0; man_ack = '0;
      s_rdata[1*DW +: DW] = 32'hCAFE_F00D;
      s_rdata[2*DW +: DW] = 32'hDEAD_BEEF;
      s_rdata[3*DW +: DW] = 32'hA5A5_A5A5;
      s_rdata[0*DW +: DW] = 32'h1234_5678;

      // Reset state
      adv(); adv(); settle();
      check("rst_s_req", 64'(s_req_o), 64'h0);
      check("rst_grant", 64'(grant_o), 64'h0);
      check("rst_ack", 64'(m_ack_o), 64'h0);
      check("rst_rdata", 64'(m_rdata_o), 64'h0);
      check("rst_hold", 64'(hold_flag_o), 64'h0);
      rst = 1'b1;
      adv();

      // Single zero-wait read by m0 from slave1
      auto_ack = 4'b1111;
      m_req = 2'b01; m_we = 2'b00; m_addr[0 +: AW] = 32'h1000_0004;
      settle();
      check("rd_c0_hold", 64'(hold_flag_o), 64'h1);
      check("rd_c0_s_req", 64'(s_req_o), 64'h0);
      adv(); settle();
      check("rd_c1_s_req", 64'(s_req_o), 64'b0010);
      check("rd_c1_grant", 64'(grant_o), 64'b01);
      check("rd_c1_hold", 64'(hold_flag_o), 64'h1);
      check("rd_c1_s_addr", 64'(s_addr_o), 64'h1000_0004);
      check("rd_c1_ack", 64'(m_ack_o), 64'h0);
      adv(); settle();
      check("rd_c2_ack", 64'(m_ack_o), 64'b01);
      check("rd_c2_rdata", 64'(m_rdata_o), 64'h0000_0000_CAFE_F00D);
      check("rd_c2_err", 64'(m_err_o), 64'h0);
      check("rd_c2_s_req", 64'(s_req_o), 64'h0);
      check("rd_c2_hold", 64'(hold_flag_o), 64'h0);
      m_req = '0;
      adv(); settle();
      check("rd_c3_grant", 64'(grant_o), 64'h0);
      check("rd_c3_ack", 64'(m_ack_o), 64'h0);

      // Write to slave2 with wait states; a stray ack from slave1 must be ignored
      auto_ack = '0;
      m_req = 2'b01; m_we = 2'b01; m_addr[0 +: AW] = 32'h2000_0000; m_wdata[0 +: DW] = 32'h55;
      adv();
      for (int c = 1; c <= 5; c++) begin
         man_ack = (c == 3) ? 4'b0010 : 4'b0000;
         settle();
         check($sformatf("wr_c%0d_s_req", c), 64'(s_req_o), 64'b0100);
         check($sformatf("wr_c%0d_we", c), 64'(s_we_o), 64'h1);
         check($sformatf("wr_c%0d_wdata", c), 64'(s_wdata_o), 64'h55);
         check($sformatf("wr_c%0d_ack", c), 64'(m_ack_o), 64'h0);
         adv();
      end
      man_ack = 4'b0100;
      settle();
      check("wr_c6_s_req", 64'(s_req_o), 64'b0100);
      check("wr_c6_ack", 64'(m_ack_o), 64'h0);
      adv();
      man_ack = '0;
      settle();
      check("wr_c7_ack", 64'(m_ack_o), 64'b01);
      check("wr_c7_err", 64'(m_err_o), 64'h0);
      check("wr_c7_rdata", 64'(m_rdata_o), 64'h0);
      m_req = '0; m_we = '0;
      adv();

      // Unmapped address from m1: error in the cycle after the request, no slave touched
      m_req = 2'b10; m_addr[1*AW +: AW] = 32'h5000_0000;
      settle();
      check("um_c0_s_req", 64'(s_req_o), 64'h0);
      adv(); settle();
      check("um_c1_ack", 64'(m_ack_o), 64'b10);
      check("um_c1_err", 64'(m_err_o), 64'b10);
      check("um_c1_rdata", 64'(m_rdata_o), 64'h0);
      check("um_c1_s_req", 64'(s_req_o), 64'h0);
      check("um_c1_grant", 64'(grant_o), 64'b10);
      m_req = '0;
      adv();

      // Slave3 never acks: error after exactly 8 BUSY cycles
      m_req = 2'b01; m_addr[0 +: AW] = 32'h3000_0000;
      adv();
      for (int c = 1; c <= 8; c++) begin
         settle();
         check($sformatf("to_c%0d_s_req", c), 64'(s_req_o), 64'b1000);
         check($sformatf("to_c%0d_ack", c), 64'(m_ack_o), 64'h0);
         adv();
      end
      settle();
      check("to_c9_ack", 64'(m_ack_o), 64'b01);
      check("to_c9_err", 64'(m_err_o), 64'b01);
      check("to_c9_rdata", 64'(m_rdata_o), 64'h0);
      check("to_c9_s_req", 64'(s_req_o), 64'h0);
      m_req = '0;
      adv();

      // Async reset while m1 waits on slave2
      m_req = 2'b10; m_we = 2'b10; m_addr[1*AW +: AW] = 32'h2000_0008; m_wdata[1*DW +: DW] = 32'h77;
      adv(); adv(); settle();
      check("ar_busy_s_req", 64'(s_req_o), 64'b0100);
      check("ar_busy_grant", 64'(grant_o), 64'b10);
      rst = 1'b0; m_req = '0; m_we = '0;
      #1;
      check("ar_s_req", 64'(s_req_o), 64'h0);
      check("ar_grant", 64'(grant_o), 64'h0);
      check("ar_s_we", 64'(s_we_o), 64'h0);
      check("ar_s_addr", 64'(s_addr_o), 64'h0);
      check("ar_s_wdata", 64'(s_wdata_o), 64'h0);
      check("ar_ack", 64'(m_ack_o), 64'h0);
      check("ar_hold", 64'(hold_flag_o), 64'h0);
      adv(); settle();
      check("ar_hold_ack", 64'(m_ack_o), 64'h0);
      rst = 1'b1;
      adv();

      // Round-robin after reset: both masters hammer zero-wait slave0
      auto_ack = 4'b1111;
      m_req = 2'b11; m_we = 2'b00;
      m_addr[0 +: AW] = 32'h0000_0010; m_addr[1*AW +: AW] = 32'h0000_0020;
      adv();
      for (int c = 1; c <= 12; c++) begin
         settle();
         check($sformatf("rr_c%0d_grant", c), 64'(grant_o), 64'(rr_grant[c-1]));
         check($sformatf("rr_c%0d_ack", c), 64'(m_ack_o), 64'(rr_ack[c-1]));
         if (c == 4) check("rr_c4_s_addr", 64'(s_addr_o), 64'h20);
         if (c == 5) check("rr_c5_rdata", 64'(m_rdata_o), 64'h1234_5678_0000_0000);
         if (c == 8) check("rr_c8_rdata", 64'(m_rdata_o), 64'h0000_0000_1234_5678);
         if (c == 8) check("rr_c8_hold", 64'(hold_flag_o), 64'h1);
         adv();
      end
      m_req = '0;
      adv();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
